// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder slice.
// Word width, implemented address width, drain FSM encodings and the
// write-buffer entry layout all live here so every file agrees on them.
// Optional feature macro used by the top: DMEM_ERR_EN.
package dmem_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 10;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/dmem_wb_fifo.sv
// Posted-store write buffer for the data-memory responder.
// Holds pending stores in FIFO order and offers a youngest-match lookup so
// loads see stores that have not reached the array yet.
module dmem_wb_fifo
    import dmem_pkg::*;
#(
    parameter int WB_DEPTH = 4,
    localparam int PTR_W = $clog2(WB_DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  wb_entry_t         pushEntry,
    input  logic              pop,
    input  logic [ADDR_W-1:0] lookupAddr,
    output logic              lookupHit,
    output logic [DATA_W-1:0] lookupData,
    output wb_entry_t         headEntry,
    output logic [CNT_W-1:0]  count
);

    wb_entry_t         entries [WB_DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [PTR_W-1:0]  idx;

    // Entry payloads need no reset; only the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            entries[tail] <= pushEntry;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally because depth is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Walk valid entries oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        lookupHit  = 1'b0;
        lookupData = '0;
        idx        = '0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if ((CNT_W'(i) < count) && (entries[idx].addr == lookupAddr)) begin
                lookupHit  = 1'b1;
                lookupData = entries[idx].data;
            end
        end
    end

    assign headEntry = entries[head];

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder at the far end of the MEM-stage load/store port.
// Loads answer combinationally (forwarding from the write buffer first),
// stores are posted into the buffer and a drain FSM commits them to the
// slow word array one every WR_LAT cycles.
// Word and address widths come from dmem_pkg.
// Optional feature: define DMEM_ERR_EN to add the sticky AddrErr output,
// drop out-of-range stores and return 0 for out-of-range loads; without it
// the upper address bits simply alias onto the array.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int WB_DEPTH = 4,
    parameter int WR_LAT   = 2,
    localparam int CNT_W = $clog2(WB_DEPTH) + 1,
    localparam int LAT_W = $clog2(WR_LAT + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRd,
    input  logic              MemWr,
    input  logic [15:0]       Addr,
    input  logic [DATA_W-1:0] DataIn,
    output logic [DATA_W-1:0] DataOut,
    output logic              MemBusy,
    output logic              WbEmpty
`ifdef DMEM_ERR_EN
    ,
    output logic              AddrErr
`endif
);

    localparam logic [LAT_W-1:0] LAT_RELOAD = LAT_W'(WR_LAT - 1);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    logic [ADDR_W-1:0] wordAddr;
    logic              inRange;
    logic              wbFull;
    logic              push;
    logic              pop;
    wb_entry_t         pushEntry;
    wb_entry_t         headEntry;
    logic              lookupHit;
    logic [DATA_W-1:0] lookupData;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  countNext;
    logic [0:0]        state;
    logic [LAT_W-1:0]  latCnt;

    assign wordAddr = Addr[ADDR_W-1:0];

`ifdef DMEM_ERR_EN
    assign inRange = (Addr[15:ADDR_W] == '0);
`else
    logic unusedAddrHi;
    assign inRange      = 1'b1;
    assign unusedAddrHi = ^Addr[15:ADDR_W];
`endif

    assign wbFull         = (count == CNT_W'(WB_DEPTH));
    assign MemBusy        = MemWr & inRange & wbFull;
    assign push           = MemWr & inRange & ~wbFull;
    assign pushEntry.addr = wordAddr;
    assign pushEntry.data = DataIn;

    assign pop       = (state == BUSY) && (latCnt == '0);
    assign countNext = count + CNT_W'(push) - CNT_W'(pop);
    assign WbEmpty   = (count == '0) && (state == IDLE);

    dmem_wb_fifo #(
        .WB_DEPTH(WB_DEPTH)
    ) wbFifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pushEntry (pushEntry),
        .pop       (pop),
        .lookupAddr(wordAddr),
        .lookupHit (lookupHit),
        .lookupData(lookupData),
        .headEntry (headEntry),
        .count     (count)
    );

    // Drain FSM: wait WR_LAT cycles per entry, pop on the last one, keep going while entries remain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            latCnt <= '0;
        end else if (state == IDLE) begin
            if (count != '0) begin
                state  <= BUSY;
                latCnt <= LAT_RELOAD;
            end
        end else begin
            if (latCnt != '0) begin
                latCnt <= latCnt - LAT_W'(1);
            end else if (countNext != '0) begin
                latCnt <= LAT_RELOAD;
            end else begin
                state <= IDLE;
            end
        end
    end

    // Array commit of the buffer head; pop is held off by reset so an in-flight store is lost.
    always_ff @(posedge clk) begin
        if (pop) begin
            mem[headEntry.addr] <= headEntry.data;
        end
    end

    // Load path: buffered data beats array data, and nothing leaves while idle or in reset.
    always_comb begin
        DataOut = '0;
        if (reset && MemRd && inRange) begin
            DataOut = lookupHit ? lookupData : mem[wordAddr];
        end
    end

`ifdef DMEM_ERR_EN
    // Sticky flag for any access that lands outside the implemented array.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            AddrErr <= 1'b0;
        end else if ((MemRd || MemWr) && !inRange) begin
            AddrErr <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder.
// A queue-based model of the posted-store buffer and a sparse array model
// predict DataOut, MemBusy, WbEmpty (and AddrErr with DMEM_ERR_EN) every
// cycle; directed scenarios add hand-computed literal expectations.
module tb_data_mem_responder;

    localparam int DEPTH = 4;
    localparam int LAT   = 4;
`ifdef DMEM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk    = 1'b0;
    logic        reset  = 1'b0;
    logic        MemRd  = 1'b0;
    logic        MemWr  = 1'b0;
    logic [15:0] Addr   = 16'h0;
    logic [15:0] DataIn = 16'h0;
    logic [15:0] DataOut;
    logic        MemBusy;
    logic        WbEmpty;
`ifdef DMEM_ERR_EN
    logic        AddrErr;
`endif

    int checkCount = 0;
    int passCount  = 0;
    bit cmpOn      = 1'b0;

    data_mem_responder #(
        .WB_DEPTH(DEPTH),
        .WR_LAT  (LAT)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .MemRd  (MemRd),
        .MemWr  (MemWr),
        .Addr   (Addr),
        .DataIn (DataIn),
        .DataOut(DataOut),
        .MemBusy(MemBusy),
        .WbEmpty(WbEmpty)
`ifdef DMEM_ERR_EN
        ,
        .AddrErr(AddrErr)
`endif
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  addr;
        logic [15:0] data;
    } modelEntry_t;

    modelEntry_t wbModel[$];
    logic [15:0] memModel [1024];
    bit          known    [1024];
    bit          drainBusy;
    int          drainWait;
    bit          errModel;

    int          sizeBefore;
    bit          doPop;
    modelEntry_t newEntry;

    function automatic bit inRangeOf(input logic [15:0] a);
        return !ERR_EN || (a[15:10] == 6'd0);
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model of the buffer: stores queue up, one leaves every LAT cycles once draining starts.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            wbModel.delete();
            drainBusy = 1'b0;
            drainWait = 0;
            errModel  = 1'b0;
        end else begin
            sizeBefore = wbModel.size();
            doPop      = 1'b0;
            if (drainBusy) begin
                if (drainWait == 0) doPop = 1'b1;
                else drainWait--;
            end else if (sizeBefore != 0) begin
                drainBusy = 1'b1;
                drainWait = LAT - 1;
            end
            if ((MemRd || MemWr) && !inRangeOf(Addr)) errModel = 1'b1;
            if (MemWr && inRangeOf(Addr) && sizeBefore < DEPTH) begin
                newEntry.addr = Addr[9:0];
                newEntry.data = DataIn;
                wbModel.push_back(newEntry);
            end
            if (doPop) begin
                newEntry = wbModel.pop_front();
                memModel[newEntry.addr] = newEntry.data;
                known[newEntry.addr]    = 1'b1;
                drainBusy = (wbModel.size() != 0);
                drainWait = LAT - 1;
            end
        end
    end

    logic [15:0] expData;
    bit          dataKnown;
    bit          modelHit;

    // Every falling edge, compare the DUT against what the model says must be visible.
    always @(negedge clk) begin
        if (cmpOn) begin
            expData   = 16'h0;
            dataKnown = 1'b1;
            modelHit  = 1'b0;
            if (reset && MemRd && inRangeOf(Addr)) begin
                foreach (wbModel[i]) begin
                    if (wbModel[i].addr == Addr[9:0]) begin
                        modelHit = 1'b1;
                        expData  = wbModel[i].data;
                    end
                end
                if (!modelHit) begin
                    dataKnown = known[Addr[9:0]];
                    expData   = memModel[Addr[9:0]];
                end
            end
            if (dataKnown) checkOutput("cmpDataOut", DataOut, expData);
            checkOutput("cmpMemBusy", 16'(MemBusy),
                        16'(reset && MemWr && inRangeOf(Addr) && wbModel.size() >= DEPTH));
            checkOutput("cmpWbEmpty", 16'(WbEmpty), 16'(wbModel.size() == 0 && !drainBusy));
`ifdef DMEM_ERR_EN
            checkOutput("cmpAddrErr", 16'(AddrErr), 16'(errModel));
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance one cycle and present a new request; returns with outputs settled.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
        step();
        MemRd  = rd;
        MemWr  = wr;
        Addr   = a;
        DataIn = d;
        #1;
    endtask

    // Present a store and hold it while MemBusy is raised.
    task automatic doStore(input logic [15:0] a, input logic [15:0] d, output int held);
        applyStimulus(1'b0, 1'b1, a, d);
        held = 0;
        while (MemBusy && held < 50) begin
            held++;
            step();
        end
        if (held >= 50) checkOutput("storeTimeout", 16'd1, 16'd0);
    endtask

    task automatic waitEmpty();
        int n;
        n = 0;
        applyStimulus(1'b0, 1'b0, 16'h0, 16'h0);
        while (!WbEmpty && n < 200) begin
            n++;
            applyStimulus(1'b0, 1'b0, 16'h0, 16'h0);
        end
        if (n >= 200) checkOutput("drainTimeout", 16'd1, 16'd0);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    int held;

    // Directed scenarios with literal expectations.
    initial begin
        reset = 1'b0;
        step();
        MemRd = 1'b1;
        MemWr = 1'b1;
        Addr  = 16'h0005;
        #1;
        checkOutput("rstDataOut", DataOut, 16'h0000);
        checkOutput("rstMemBusy", 16'(MemBusy), 16'd0);
        checkOutput("rstWbEmpty", 16'(WbEmpty), 16'd1);
        MemRd = 1'b0;
        MemWr = 1'b0;
        step();
        reset = 1'b1;
        cmpOn = 1'b1;

        // Store then immediate load is forwarded from the buffer.
        doStore(16'h0010, 16'hBEEF, held);
        applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0);
        checkOutput("fwdLoad", DataOut, 16'hBEEF);
        checkOutput("fwdMemBusy", 16'(MemBusy), 16'd0);

        // Back-to-back stores overflow the buffer; the fifth waits for the first commit.
        waitEmpty();
        for (int i = 1; i <= 4; i++) begin
            doStore(16'(i), 16'h0A00 + 16'(i), held);
            checkOutput("fillNoStall", 16'(held), 16'd0);
        end
        doStore(16'h0005, 16'h0A05, held);
        checkOutput("fullStallCycles", 16'(held), 16'd2);
        waitEmpty();
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b1, 1'b0, 16'(i), 16'h0);
            checkOutput("drainedLoad", DataOut, 16'h0A00 + 16'(i));
        end

        // Two stores to one address: youngest wins in the buffer and in the array.
        doStore(16'h0020, 16'h1111, held);
        doStore(16'h0020, 16'h2222, held);
        applyStimulus(1'b1, 1'b0, 16'h0020, 16'h0);
        checkOutput("youngestFwd", DataOut, 16'h2222);
        waitEmpty();
        applyStimulus(1'b1, 1'b0, 16'h0020, 16'h0);
        checkOutput("youngestArray", DataOut, 16'h2222);

        // Reset while a store is draining throws it away.
        doStore(16'h0030, 16'hAAAA, held);
        waitEmpty();
        doStore(16'h0030, 16'h5555, held);
        applyStimulus(1'b0, 1'b0, 16'h0, 16'h0);
        applyStimulus(1'b0, 1'b0, 16'h0, 16'h0);
        checkOutput("busyBeforeRst", 16'(WbEmpty), 16'd0);
        reset = 1'b0;
        #1;
        checkOutput("rstMidDrainEmpty", 16'(WbEmpty), 16'd1);
        step();
        step();
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 16'h0030, 16'h0);
        checkOutput("rstKeepsArray", DataOut, 16'hAAAA);

        // A lone store drains on its own within 2*LAT quiet cycles.
        waitEmpty();
        doStore(16'h0040, 16'h7777, held);
        applyStimulus(1'b0, 1'b0, 16'h0, 16'h0);
        checkOutput("loneStorePending", 16'(WbEmpty), 16'd0);
        repeat (2 * LAT) applyStimulus(1'b0, 1'b0, 16'h0, 16'h0);
        checkOutput("loneStoreDrained", 16'(WbEmpty), 16'd1);
        checkOutput("noReadZero", DataOut, 16'h0000);

        // Load and store in the same cycle: the load sees the older value.
        doStore(16'h0050, 16'h1357, held);
        waitEmpty();
        applyStimulus(1'b1, 1'b1, 16'h0050, 16'h9999);
        checkOutput("rdWrSameCycle", DataOut, 16'h1357);
        applyStimulus(1'b1, 1'b0, 16'h0050, 16'h0);
        checkOutput("rdAfterRdWr", DataOut, 16'h9999);
        waitEmpty();

`ifdef DMEM_ERR_EN
        // Out-of-range store is dropped and flagged; out-of-range load reads zero.
        checkOutput("errClear", 16'(AddrErr), 16'd0);
        applyStimulus(1'b0, 1'b1, 16'h0400, 16'h1234);
        checkOutput("oorNoBusy", 16'(MemBusy), 16'd0);
        applyStimulus(1'b0, 1'b0, 16'h0, 16'h0);
        checkOutput("oorErrSet", 16'(AddrErr), 16'd1);
        checkOutput("oorStillEmpty", 16'(WbEmpty), 16'd1);
        applyStimulus(1'b1, 1'b0, 16'h0400, 16'h0);
        checkOutput("oorLoadZero", DataOut, 16'h0000);
        applyStimulus(1'b0, 1'b0, 16'h0, 16'h0);
        checkOutput("errSticky", 16'(AddrErr), 16'd1);
`else
        // Upper address bits alias onto the array.
        applyStimulus(1'b1, 1'b0, 16'h0410, 16'h0);
        checkOutput("aliasLoad", DataOut, 16'hBEEF);
`endif

        applyStimulus(1'b0, 1'b0, 16'h0, 16'h0);
        step();
        cmpOn = 1'b0;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
